// File: rtl/adc_spi_reader_if.sv
// Bus bundle between adc_spi_reader (master) and its ADC / sample consumer (slave).
interface adc_spi_reader_if #(
  parameter int unsigned DATA_W = 12
);
  logic              req;
  logic              adc_sdata;
  logic              adc_cs_n;
  logic              adc_sclk;
  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              busy;
  logic              overrun;
  logic              frame_err;

  modport master (
    input  req, adc_sdata,
    output adc_cs_n, adc_sclk, sample, sample_valid, busy, overrun, frame_err
  );

  modport slave (
    output req, adc_sdata,
    input  adc_cs_n, adc_sclk, sample, sample_valid, busy, overrun, frame_err
  );
endinterface

// File: rtl/adc_spi_reader.sv
// Serial ADC capture: one SPI read frame per req rising edge, 12-bit sample + valid strobe.
// Optional ADC_SIGNED_EN: convert offset-binary sample to two's complement.
module adc_spi_reader #(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned FRAME_BITS = 16,
  parameter int unsigned DATA_W     = 12
) (
  input  logic             clk,
  input  logic             rst,
  adc_spi_reader_if.master bus
);
  localparam int unsigned BCW = $clog2(FRAME_BITS);
  localparam logic [7:0]     DIV_LOAD   = 8'(CLK_DIV - 1);
  localparam logic [7:0]     SETUP_LOAD = 8'(CLK_DIV);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(FRAME_BITS - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t                state;
  logic                  req_q;
  logic                  start;
  logic [7:0]            div_cnt;
  logic [BCW-1:0]        bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic [DATA_W-1:0]     raw;
  logic [DATA_W-1:0]     conv;

  assign start = bus.req & ~req_q;
  assign raw   = shift[DATA_W-1:0];

`ifdef ADC_SIGNED_EN
  assign conv = raw ^ {1'b1, {(DATA_W-1){1'b0}}};
`else
  assign conv = raw;
`endif

  // SETUP loads CLK_DIV (one extra cycle) and HOLD spends one cycle with
  // cs_n already high, giving the 1 + CLK_DIV*(2*FRAME_BITS+2) + 1 latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      req_q            <= 1'b0;
      div_cnt          <= '0;
      bit_cnt          <= '0;
      shift            <= '0;
      bus.adc_cs_n     <= 1'b1;
      bus.adc_sclk     <= 1'b1;
      bus.sample       <= '0;
      bus.sample_valid <= 1'b0;
      bus.busy         <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.frame_err    <= 1'b0;
    end else begin
      req_q            <= bus.req;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
      bus.frame_err    <= 1'b0;

      if (start && state != IDLE) bus.overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            state        <= SETUP;
            bus.adc_cs_n <= 1'b0;
            bus.busy     <= 1'b1;
            div_cnt      <= SETUP_LOAD;
            shift        <= '0;
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            state        <= SHIFT;
            bus.adc_sclk <= 1'b0;
            div_cnt      <= DIV_LOAD;
            bit_cnt      <= '0;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 8'd1;
          end else begin
            div_cnt <= DIV_LOAD;
            if (!bus.adc_sclk) begin
              bus.adc_sclk <= 1'b1;
              shift        <= {shift[FRAME_BITS-2:0], bus.adc_sdata};
            end else if (bit_cnt == BIT_LAST) begin
              state <= HOLD;
            end else begin
              bit_cnt      <= bit_cnt + 1'b1;
              bus.adc_sclk <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 8'd1;
          end else if (!bus.adc_cs_n) begin
            bus.adc_cs_n <= 1'b1;
          end else begin
            state            <= DONE;
            bus.sample       <= conv;
            bus.sample_valid <= 1'b1;
            bus.frame_err    <= |shift[FRAME_BITS-1:DATA_W];
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/adc_spi_reader.md
Name: adc_spi_reader

Overview:
- Serial ADC capture controller that consumes the synchronized read request produced by the team's request-synchronizer stage (get_rdid_debounce).
- On each rising edge of that request, runs one 16-bit SPI-style read frame on a 12-bit serial ADC (4 leading zeros, then 12 data bits, MSB first).
- Presents the 12-bit sample with a one-cycle valid strobe to the tuner's sample buffer / frequency-detection datapath.

Parameters:
- CLK_DIV, 4, clk cycles per SCLK half-period; legal range 2..255.
- FRAME_BITS, 16, SCLK cycles per frame; must be at least DATA_W + 1.
- DATA_W, 12, sample width; the sample is the last DATA_W bits of the frame.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- req  in  1  synchronized read request (get_rdid_debounce); level input, rising edge starts a frame.
- adc_sdata  in  1  ADC serial data out.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_sclk  out  1  ADC serial clock, idles high.
- sample  out  DATA_W  last captured sample; held between frames.
- sample_valid  out  1  one-cycle pulse when sample updates.
- busy  out  1  high from frame start until the cycle sample_valid pulses, inclusive.
- overrun  out  1  one-cycle pulse when a req rising edge arrives while busy.
- frame_err  out  1  one-cycle pulse, coincident with sample_valid, when any leading bit was 1.

Behaviour:
- Reset rst is asynchronous and active-high; the clock is clk. Reset values:
  - adc_cs_n=1, adc_sclk=1
  - sample=0, sample_valid=0, busy=0, overrun=0, frame_err=0
  - req edge register=0, state=IDLE
- Edge detect: req_q registers req each clk; start = req & ~req_q.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE.
  - IDLE: start -> SETUP. Next cycle: adc_cs_n=0, busy=1.
  - SETUP: adc_cs_n low, adc_sclk high for CLK_DIV cycles -> SHIFT.
  - SHIFT: FRAME_BITS SCLK periods.
    - Each period is CLK_DIV cycles with adc_sclk low, then CLK_DIV cycles with adc_sclk high.
    - adc_sdata is shifted in on the clk edge where adc_sclk is driven low->high.
    - A bit counter counts 0..FRAME_BITS-1. After the last high half -> HOLD.
  - HOLD: adc_sclk high, adc_cs_n low for CLK_DIV cycles; then adc_cs_n=1 -> DONE.
  - DONE: for one cycle, sample <= shift[DATA_W-1:0], sample_valid=1, frame_err=|shift[FRAME_BITS-1:DATA_W]. Next cycle -> IDLE, busy=0.
- Latency: sample_valid rises exactly 1 + CLK_DIV*(2*FRAME_BITS + 2) + 1 cycles after the edge where start=1. Defaults: 1 + 4*34 + 1 = 138.
- Overlap rules:
  - A start while busy, including in DONE, is dropped (no queue) and raises overrun for one cycle.
  - A start in the cycle after DONE (state IDLE) is accepted normally.
- req held high does not retrigger; a new frame needs req to fall and rise again.
- Reset mid-frame: outputs return to reset values immediately (adc_cs_n high asynchronously); the partial frame is discarded and no sample_valid is issued.
- The shift register is cleared at SETUP entry, so no stale bits carry across frames.
- The SCLK divider counter is 8 bits wide, reloads at each half-period, and wraps only via reload, never by overflow.

Optional Feature:
- Macro: ADC_SIGNED_EN.
- Defined: sample = raw ^ (1 << (DATA_W-1)), i.e. offset-binary converted to two's complement centred at mid-scale. With DATA_W=12: raw 0x800 -> 0x000, 0x000 -> 0x800 (-2048), 0xFFF -> 0x7FF.
- Undefined: sample = raw unsigned; no extra logic.
- Conversion is combinational on the DONE load; latency is unchanged.

Test Plan:
- ADC model returns frame 0x0ABC, single req pulse -> exactly 16 SCLK low pulses while adc_cs_n=0; sample=0xABC, sample_valid high for 1 cycle at 138 cycles after start; frame_err=0; busy drops the next cycle.
- Frame 0x8123 (leading bit set) -> sample=0x123, frame_err=1 coincident with sample_valid.
- Second req rising edge 50 cycles after the first -> overrun pulses once; only one sample_valid (1 total).
- req held high for 400 cycles -> exactly one frame.
- req falls, then rises again at cycle 200 -> second frame captures 0x555 from model frame 0x0555.
- rst asserted at cycle 70 of a frame -> adc_cs_n=1 and adc_sclk=1 immediately; no sample_valid.
  - Next req -> clean frame with the correct sample 0xFFF from frame 0x0FFF.
- ADC_SIGNED_EN defined, frames 0x0800, 0x0000, 0x0FFF -> sample 0x000, 0x800, 0x7FF respectively.
